thash_fh: RTL and testbench

- Runtime-selectable tweakable hash for the WOTS/L-tree datapath.
- mode=0 computes thash_f: one-block input, used in chain steps. It takes PRF(key), PRF(mask0), then the core hash.
- mode=1 computes thash_h: two-block input, used in L-tree and tree nodes. It takes PRF(key), PRF(mask0), PRF(mask1), then the core hash.
- Drives one shared sha256 core through the standard start/done handshake.
- Holds its result in a register, so callers no longer read the live sha256 output.

---
 rtl/xmss_hash_pkg.sv | 29 ++
 rtl/thash_fh_if.sv | 29 ++
 rtl/thash_msg_mux.sv | 35 +++
 rtl/thash_fh.sv | 118 +++++++++++
 tb/tb_thash_fh.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xmss_hash_pkg.sv
// Shared constants and FSM encoding for the XMSS tweakable-hash datapath.
package xmss_hash_pkg;
    localparam int KEY_LEN               = 256;
    localparam int XMSS_HASH_PADDING_F   = 0;
    localparam int XMSS_HASH_PADDING_H   = 1;
    localparam int XMSS_HASH_PADDING_PRF = 3;

    localparam logic [31:0] KAM_KEY   = 32'd0;
    localparam logic [31:0] KAM_MASK0 = 32'd1;
    localparam logic [31:0] KAM_MASK1 = 32'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRF_KEY = 3'd1,
        PRF_M0  = 3'd2,
        PRF_M1  = 3'd3,
        CORE    = 3'd4,
        FIN     = 3'd5
    } state_t;

    // keyAndMask word carried by the PRF issued on entry to a state
    function automatic logic [31:0] kam_of(input state_t s);
        case (s)
            PRF_M0:  return KAM_MASK0;
            PRF_M1:  return KAM_MASK1;
            default: return KAM_KEY;
        endcase
    endfunction
endpackage

// File: rtl/thash_fh_if.sv
// Caller request/result signals plus the sha256 core handshake.
interface thash_fh_if;
    import xmss_hash_pkg::*;

    logic                   start;
    logic                   mode;
    logic [KEY_LEN-1:0]     input_key;
    logic [2*KEY_LEN-1:0]   input_data;
    logic [255:0]           hash_addr;
    logic [KEY_LEN-1:0]     data_out;
    logic                   done;
    logic                   busy;
    logic [255:0]           hash_addr_updated;
    logic                   hash_done;
    logic [KEY_LEN-1:0]     hash_data_out;
    logic                   hash_start;
    logic [4*KEY_LEN-1:0]   hash_data_in;
    logic                   message_length;

    modport slave (
        input  start, mode, input_key, input_data, hash_addr, hash_done, hash_data_out,
        output data_out, done, busy, hash_addr_updated, hash_start, hash_data_in, message_length
    );

    modport master (
        output start, mode, input_key, input_data, hash_addr, hash_done, hash_data_out,
        input  data_out, done, busy, hash_addr_updated, hash_start, hash_data_in, message_length
    );
endinterface

// File: rtl/thash_msg_mux.sv
// Builds the 1024-bit sha256 message for the state about to be entered.
module thash_msg_mux #(
    parameter int KEY_LEN               = 256,
    parameter int XMSS_HASH_PADDING_F   = 0,
    parameter int XMSS_HASH_PADDING_H   = 1,
    parameter int XMSS_HASH_PADDING_PRF = 3
) (
    input  xmss_hash_pkg::state_t  i_tgt,
    input  logic                   i_mode,
    input  logic [KEY_LEN-1:0]     i_seed,
    input  logic [223:0]           i_addr_hi,
    input  logic [2*KEY_LEN-1:0]   i_data,
    input  logic [KEY_LEN-1:0]     i_prf_key,
    input  logic [KEY_LEN-1:0]     i_mask0,
    input  logic [KEY_LEN-1:0]     i_mask1,
    output logic [4*KEY_LEN-1:0]   o_msg,
    output logic                   o_len
);
    import xmss_hash_pkg::*;

    always_comb begin
        o_msg = {KEY_LEN'(XMSS_HASH_PADDING_PRF), i_seed, i_addr_hi, kam_of(i_tgt), {KEY_LEN{1'b0}}};
        o_len = 1'b0;
        if (i_tgt == CORE) begin
            if (i_mode) begin
                o_msg = {KEY_LEN'(XMSS_HASH_PADDING_H), i_prf_key,
                         i_mask0 ^ i_data[2*KEY_LEN-1:KEY_LEN], i_mask1 ^ i_data[KEY_LEN-1:0]};
                o_len = 1'b1;
            end else begin
                o_msg = {KEY_LEN'(XMSS_HASH_PADDING_F), i_prf_key,
                         i_mask0 ^ i_data[KEY_LEN-1:0], {KEY_LEN{1'b0}}};
            end
        end
    end
endmodule

// File: rtl/thash_fh.sv
// thash_f / thash_h sequencer: PRF key, PRF masks, then core hash on a shared sha256.
module thash_fh #(
    parameter int KEY_LEN               = 256,
    parameter int XMSS_HASH_PADDING_F   = 0,
    parameter int XMSS_HASH_PADDING_H   = 1,
    parameter int XMSS_HASH_PADDING_PRF = 3
) (
    input  logic        clk,
    input  logic        reset,
    thash_fh_if.slave   bus
);
    import xmss_hash_pkg::*;

    state_t                 r_state;
    logic                   r_mode, r_busy, r_done, r_hash_start, r_msg_len;
    logic [KEY_LEN-1:0]     r_seed, r_prf_key, r_mask0, r_data_out;
    logic [2*KEY_LEN-1:0]   r_data;
    logic [223:0]           r_addr_hi;
    logic [31:0]            r_kam;
    logic [4*KEY_LEN-1:0]   r_hash_data_in;

    state_t                 w_tgt;
    logic                   w_adv, w_load, w_len;
    logic [KEY_LEN-1:0]     w_seed, w_mask0;
    logic [223:0]           w_addr_hi;
    logic [4*KEY_LEN-1:0]   w_msg;
    logic                   w_unused_addr;

    assign w_unused_addr = ^bus.hash_addr[31:0];

    // On accept the message is built from the live inputs, not the not-yet-captured registers
    always_comb begin
        w_tgt     = IDLE;
        w_adv     = 1'b0;
        w_seed    = r_seed;
        w_addr_hi = r_addr_hi;
        w_mask0   = r_mask0;
        case (r_state)
            IDLE, FIN: begin
                w_tgt     = bus.start ? PRF_KEY : IDLE;
                w_adv     = bus.start || (r_state == FIN);
                w_seed    = bus.input_key;
                w_addr_hi = bus.hash_addr[255:32];
            end
            PRF_KEY: begin w_tgt = PRF_M0; w_adv = bus.hash_done; end
            PRF_M0: begin
                w_tgt   = r_mode ? PRF_M1 : CORE;
                w_adv   = bus.hash_done;
                w_mask0 = bus.hash_data_out;
            end
            PRF_M1:  begin w_tgt = CORE; w_adv = bus.hash_done; end
            CORE:    begin w_tgt = FIN;  w_adv = bus.hash_done; end
            default: begin w_tgt = IDLE; w_adv = 1'b1; end
        endcase
    end

    assign w_load = w_adv && (w_tgt inside {PRF_KEY, PRF_M0, PRF_M1, CORE});

    thash_msg_mux #(
        .KEY_LEN(KEY_LEN), .XMSS_HASH_PADDING_F(XMSS_HASH_PADDING_F),
        .XMSS_HASH_PADDING_H(XMSS_HASH_PADDING_H), .XMSS_HASH_PADDING_PRF(XMSS_HASH_PADDING_PRF)
    ) u_mux (
        .i_tgt(w_tgt), .i_mode(r_mode), .i_seed(w_seed), .i_addr_hi(w_addr_hi),
        .i_data(r_data), .i_prf_key(r_prf_key), .i_mask0(w_mask0),
        .i_mask1(bus.hash_data_out), .o_msg(w_msg), .o_len(w_len)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_mode         <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_hash_start   <= 1'b0;
            r_msg_len      <= 1'b0;
            r_seed         <= '0;
            r_prf_key      <= '0;
            r_mask0        <= '0;
            r_data_out     <= '0;
            r_data         <= '0;
            r_addr_hi      <= '0;
            r_kam          <= '0;
            r_hash_data_in <= '0;
        end else begin
            r_hash_start <= 1'b0;
            r_done       <= 1'b0;
            if (w_adv) r_state <= w_tgt;
            if (w_adv && w_tgt == PRF_KEY) begin
                r_mode    <= bus.mode;
                r_seed    <= bus.input_key;
                r_data    <= bus.input_data;
                r_addr_hi <= bus.hash_addr[255:32];
                r_busy    <= 1'b1;
            end
            if (w_load) begin
                r_hash_start   <= 1'b1;
                r_hash_data_in <= w_msg;
                r_msg_len      <= w_len;
                if (w_tgt != CORE) r_kam <= kam_of(w_tgt);
            end
            if (w_adv && r_state == PRF_KEY) r_prf_key <= bus.hash_data_out;
            if (w_adv && r_state == PRF_M0)  r_mask0   <= bus.hash_data_out;
            if (w_adv && w_tgt == FIN) begin
                r_data_out <= bus.hash_data_out;
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
            end
        end
    end

    assign bus.data_out          = r_data_out;
    assign bus.done              = r_done;
    assign bus.busy              = r_busy;
    assign bus.hash_addr_updated = {r_addr_hi, r_kam};
    assign bus.hash_start        = r_hash_start;
    assign bus.hash_data_in      = r_hash_data_in;
    assign bus.message_length    = r_msg_len;
endmodule

// File: tb/tb_thash_fh.sv
// Scoreboarded bench for thash_fh with a behavioural sha256 stand-in of configurable latency.
module tb_thash_fh;
    import xmss_hash_pkg::*;

    typedef struct { logic [1023:0] msg; logic len; } msg_t;
    typedef struct { logic [255:0] dig; logic [255:0] upd; int t0; int lat; } res_t;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic m_done     = 1'b0;
    logic stray_done = 1'b0;
    int   checks = 0, failures = 0, cyc = 0;
    int   n_done = 0, n_hstart = 0, n_hdone = 0;
    int   sha_lat = 10;
    msg_t exp_msg[$];
    res_t exp_res[$];

    thash_fh_if bus();
    thash_fh dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.hash_done = m_done | stray_done;

    // Stand-in digest: any mixing function works, the DUT only forwards it
    function automatic logic [255:0] fs(input logic [1023:0] m, input logic len);
        logic [255:0] h;
        h = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
        for (int i = 0; i < 4; i++) h = (h + m[i*256 +: 256]) ^ {h[180:0], h[255:181]};
        return h ^ {255'd0, len};
    endfunction

    function automatic logic [1023:0] prf(input logic [255:0] key, input logic [255:0] addr,
                                          input logic [31:0] k);
        return {256'd3, key, addr[255:32], k, 256'd0};
    endfunction

    function automatic logic [255:0] r256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_msg(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        logic [255:0] a, e;
        int c;
        checks++;
        if (act !== exp) begin
            failures++;
            c = 3;
            while (c > 0 && act[c*256 +: 256] === exp[c*256 +: 256]) c--;
            a = act[c*256 +: 256];
            e = exp[c*256 +: 256];
            $display("FAIL %s: word %0d got %h expected %h", name, c, a, e);
        end
    endtask

    // Reference model: the whole F/H computation from the operands
    task automatic push_op(input logic mode, input logic [255:0] key, input logic [511:0] data,
                           input logic [255:0] addr);
        logic [255:0]  kr, m0, m1;
        logic [1023:0] p;
        msg_t e;
        res_t r;
        p = prf(key, addr, 32'd0); e.msg = p; e.len = 1'b0; exp_msg.push_back(e); kr = fs(p, 1'b0);
        p = prf(key, addr, 32'd1); e.msg = p; exp_msg.push_back(e); m0 = fs(p, 1'b0);
        if (mode) begin
            p = prf(key, addr, 32'd2); e.msg = p; exp_msg.push_back(e); m1 = fs(p, 1'b0);
            e.msg = {256'd1, kr, m0 ^ data[511:256], m1 ^ data[255:0]};
            e.len = 1'b1;
        end else begin
            e.msg = {256'd0, kr, m0 ^ data[255:0], 256'd0};
            e.len = 1'b0;
        end
        exp_msg.push_back(e);
        r.dig = fs(e.msg, e.len);
        r.upd = {addr[255:32], mode ? 32'd2 : 32'd1};
        r.t0  = cyc;
        r.lat = (mode ? 4 : 3) * (sha_lat + 1) + 1;
        exp_res.push_back(r);
    endtask

    initial begin : sha_model
        int cnt;
        logic pend;
        logic [255:0] dig;
        msg_t e;
        cnt = 0; pend = 1'b0; dig = '0;
        bus.hash_data_out = '0;
        forever begin
            @(posedge clk); #1;
            m_done = 1'b0;
            if (reset) pend = 1'b0;
            else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        m_done = 1'b1; bus.hash_data_out = dig; pend = 1'b0; n_hdone++;
                    end
                end
                if (bus.hash_start) begin
                    n_hstart++;
                    chk_int("hash_start_while_pending", int'(pend), 0);
                    if (exp_msg.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_hash_start: got a request, expected none");
                    end else begin
                        e = exp_msg.pop_front();
                        chk_msg("hash_data_in", bus.hash_data_in, e.msg);
                        chk_int("message_length", int'(bus.message_length), int'(e.len));
                    end
                    pend = 1'b1; cnt = sha_lat;
                    dig = fs(bus.hash_data_in, bus.message_length);
                end
            end
        end
    end

    initial begin : done_monitor
        res_t r;
        forever begin
            @(posedge clk); #1;
            if (!reset && bus.done) begin
                n_done++;
                if (exp_res.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    r = exp_res.pop_front();
                    chk("data_out", bus.data_out, r.dig);
                    chk("hash_addr_updated", bus.hash_addr_updated, r.upd);
                    chk_int("latency", cyc - r.t0, r.lat);
                    chk_int("busy_in_fin", int'(bus.busy), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic launch(input logic mode, input logic [255:0] key, input logic [511:0] data,
                          input logic [255:0] addr);
        bus.start = 1'b1; bus.mode = mode; bus.input_key = key;
        bus.input_data = data; bus.hash_addr = addr;
        push_op(mode, key, data, addr);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic perturb(input int n);
        repeat (n) begin
            bus.input_data = {r256(), r256()}; bus.hash_addr = r256();
            bus.input_key = r256(); bus.mode = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_res.size() != 0 || bus.busy) && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL idle_timeout: %0d results outstanding after %0d cycles, expected 0", exp_res.size(), n);
            exp_res.delete(); exp_msg.delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk_int({tag, "_busy"}, int'(bus.busy), 0);
        chk_int({tag, "_done"}, int'(bus.done), 0);
        chk_int({tag, "_hash_start"}, int'(bus.hash_start), 0);
        chk_int({tag, "_msg_len"}, int'(bus.message_length), 0);
        chk({tag, "_data_out"}, bus.data_out, '0);
        chk({tag, "_addr_upd"}, bus.hash_addr_updated, '0);
        chk_msg({tag, "_hash_data_in"}, bus.hash_data_in, '0);
    endtask

    initial begin : stim
        logic [255:0] key, addr, a, b, h_dig;
        int hs0, d0, hd0, n;
        logic md;
        bus.start = 1'b0; bus.mode = 1'b0; bus.input_key = '0;
        bus.input_data = '0; bus.hash_addr = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // H run, L=10
        key = {8{32'h11111111}}; addr = r256(); a = r256(); b = r256();
        hs0 = n_hstart;
        launch(1'b1, key, {a, b}, addr);
        chk_int("h_busy_after_start", int'(bus.busy), 1);
        wait_idle(300);
        chk_int("h_hash_start_count", n_hstart - hs0, 4);

        // F run, upper data half is don't-care
        hs0 = n_hstart;
        launch(1'b0, key, {r256(), r256()}, addr);
        wait_idle(300);
        chk_int("f_hash_start_count", n_hstart - hs0, 3);

        // start while busy must be ignored
        launch(1'b1, key, {a, b}, addr);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.input_key = ~key;
        bus.input_data = {b, a}; bus.hash_addr = r256();
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(300);

        // reset on the 2nd hash_done, then a stray hash_done
        hd0 = n_hdone;
        launch(1'b1, r256(), {r256(), r256()}, r256());
        n = 0;
        while (n_hdone < hd0 + 2 && n < 200) begin @(negedge clk); n++; end
        chk_int("reset_reach_2nd_hash_done", n_hdone - hd0, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_res.delete(); exp_msg.delete();
        hs0 = n_hstart; d0 = n_done;
        repeat (2) @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (4) @(negedge clk);
        chk_int("abort_no_hash_start", n_hstart - hs0, 0);
        chk_int("abort_no_done", n_done - d0, 0);
        chk_all_zero("abort");
        launch(1'b0, r256(), {r256(), r256()}, r256());
        wait_idle(300);

        // back-to-back: F start in the FIN cycle of an H run
        launch(1'b1, r256(), {r256(), r256()}, r256());
        h_dig = exp_res[$].dig;
        n = 0;
        while (!bus.done && n < 300) begin @(negedge clk); n++; end
        chk_int("b2b_reached_fin", int'(bus.done), 1);
        launch(1'b0, r256(), {r256(), r256()}, r256());
        chk_int("b2b_hash_start_next_cycle", int'(bus.hash_start), 1);
        chk_int("b2b_busy", int'(bus.busy), 1);
        repeat (15) @(negedge clk);
        chk("b2b_data_out_held", bus.data_out, h_dig);
        wait_idle(300);

        // operands captured at start: inputs churn every cycle afterwards
        launch(1'b0, r256(), {r256(), r256()}, r256());
        perturb(40);
        wait_idle(300);
        launch(1'b1, r256(), {r256(), r256()}, r256());
        perturb(50);
        wait_idle(300);

        // randomized modes, latencies and gaps
        for (int i = 0; i < 24; i++) begin
            sha_lat = $urandom_range(1, 12);
            md = 1'($urandom);
            launch(md, r256(), {r256(), r256()}, r256());
            if ($urandom_range(0, 1) == 1) perturb($urandom_range(1, 8));
            wait_idle(400);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk_int("leftover_messages", exp_msg.size(), 0);
        chk_int("leftover_results", exp_res.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
